// File: rtl/frame_buffer_receiver.sv
// Frame-buffer stream sink: in-order pixel capture into a small FIFO, popped by the host.
// Build macro FB_RX_SEQ_ERR_EN enables skipped-pixel and early frame_done detection.
`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif
`ifndef FRAME_BUFFER_ADDR_SIZE
`define FRAME_BUFFER_ADDR_SIZE 19
`endif

module frame_buffer_receiver #(
    parameter int PIXELS = `WIDTH * `HEIGHT,
    parameter int ADDR_W = `FRAME_BUFFER_ADDR_SIZE,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [31:0]       pixel_data,
    input  logic [ADDR_W-1:0] pixel_addr,
    input  logic              frame_done,
    output logic              ready_for_data,
    input  logic              rd_en,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic              frame_received,
    output logic              seq_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, RECEIVE, DRAIN, DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] expected_addr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [23:0]       mem_q [DEPTH];
    logic [31:0]       rd_data_q;
    logic              rd_valid_q;
    logic              frame_received_q;
    logic              seq_err_q;
    logic              push;
    logic              pop;
    logic              skip;
    logic              early_end;
    logic              unused_bits;

    assign ready_for_data = (state_q == RECEIVE) && (count_q < DEPTH_CNT);
    assign push           = ready_for_data && (pixel_addr == expected_addr_q);
    assign pop            = rd_en && (count_q != '0);
    assign count_d        = count_q + CNT_W'(push) - CNT_W'(pop);

`ifdef FB_RX_SEQ_ERR_EN
    assign skip        = ready_for_data && (pixel_addr > expected_addr_q);
    assign early_end   = (state_q == RECEIVE) && frame_done;
    assign unused_bits = ^pixel_data[31:24];
`else
    assign skip        = 1'b0;
    assign early_end   = 1'b0;
    assign unused_bits = ^{pixel_data[31:24], frame_done};
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q          <= IDLE;
            expected_addr_q  <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            rd_data_q        <= '0;
            rd_valid_q       <= 1'b0;
            frame_received_q <= 1'b0;
            seq_err_q        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q          <= count_d;
            rd_valid_q       <= pop;
            frame_received_q <= 1'b0;
            if (push) begin
                mem_q[wr_ptr_q] <= pixel_data[23:0];
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                expected_addr_q <= expected_addr_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_data_q <= {8'h00, mem_q[rd_ptr_q]};
                rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q         <= RECEIVE;
                        expected_addr_q <= '0;
                        seq_err_q       <= 1'b0;
                    end
                end
                RECEIVE: begin
                    if (skip || early_end) begin
                        seq_err_q <= 1'b1;
                    end
                    if ((push && (pixel_addr == LAST_ADDR)) || early_end) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // count_d already reflects a pop in this cycle
                    if (count_d == '0) begin
                        state_q          <= DONE;
                        frame_received_q <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_data        = rd_data_q;
    assign rd_valid       = rd_valid_q;
    assign frame_received = frame_received_q;
    assign seq_err        = seq_err_q;

endmodule
